vend_sequencer: RTL and testbench
=================================

# vend_sequencer

Control sequencer for the two-item vending machine. It accumulates coin credit, accepts an item selection once credit covers the price, and drives the dispense mechanism and the change hopper through req/ack handshakes. It sits between the front-panel inputs (coin slot, select buttons, cancel) and the physical actuators, and replaces ad-hoc change logic with a single credit register.

## Interface
Parameters:
- PRICE_COLA, 10: price of item 01, in Rs.
- PRICE_PEPSI, 15: price of item 10, in Rs.
- CREDIT_MAX, 30: maximum credit; any coin that would exceed it is rejected.
- TIMEOUT_CYC, 1000: idle cycles in COLLECT before an automatic refund.
- CW, 6: credit width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin  in  2  one-cycle coin pulse: 01 = Rs5, 10 = Rs10, 00 = none, 11 = invalid and ignored.
- sel  in  2  item select: 01 = CocaCola, 10 = Pepsi, 00/11 = none.
- cancel  in  1  refund request.
- disp_req  out  2  one-hot item to dispense; held until acknowledged.
- disp_ack  in  1  dispense complete.
- disp_fault  in  1  dispense failed.
- hop_req  out  2  change coin to pay: 01 = Rs5, 10 = Rs10; held until acknowledged.
- hop_ack  in  1  coin paid.
- credit  out  CW  current credit in Rs.
- busy  out  1  high in VEND and CHANGE.
- coin_reject  out  1  one-cycle pulse: the coin was not accepted.
- vend_done  out  1  one-cycle pulse on a successful dispense.
- err  out  1  one-cycle pulse on disp_fault.

## Operation
- States:
  - IDLE: credit = 0.
  - COLLECT: credit > 0.
  - VEND: disp_req active.
  - CHANGE: paying out credit.
- Coin handling in IDLE and COLLECT:
  - A valid coin is added to credit if the sum ≤ CREDIT_MAX; otherwise coin_reject pulses.
  - In IDLE, an accepted coin moves the block to COLLECT.
- Coins arriving in VEND or CHANGE are always rejected.
- COLLECT priority order (highest first):
  1. cancel: go to CHANGE; any same-cycle coin is rejected.
  2. sel: a valid sel whose price ≤ the pre-coin credit goes to VEND and latches the item. A same-cycle coin is still accepted.
  3. A sel with insufficient credit is ignored; the block stays in COLLECT.
- cancel in IDLE has no effect.
- VEND:
  - On disp_ack, subtract the latched price and pulse vend_done. Go to CHANGE if the remaining credit > 0, else IDLE.
  - On disp_fault, credit is unchanged, err pulses, and the block goes to CHANGE (full refund).
  - disp_ack takes priority over a simultaneous disp_fault.
- CHANGE:
  - Pay a Rs10 coin while credit ≥ 10, otherwise a Rs5 coin.
  - On hop_ack, subtract the coin value.
  - When credit reaches 0, go to IDLE.
- Credit is always a multiple of 5. Subtraction never underflows; an underflow is an assertion failure in the bench.
- Timeout:
  - The counter runs only in COLLECT and clears on every accepted coin.
  - When the count reaches TIMEOUT_CYC, the block goes to CHANGE.
- sel, cancel and hop/disp acks are ignored in any state where they are not listed above.

## Timing
- Reset values: all outputs 0, state IDLE, credit 0, timeout counter 0.
- Reset asserted mid-operation aborts immediately. Any held credit is discarded; this is the documented behaviour.
- All outputs are registered.
- credit updates the cycle after an accepted coin or an ack.
- coin_reject pulses the cycle after the offending coin.
- disp_req asserts the cycle after sel is accepted and drops the cycle after disp_ack.
- Change coins:
  - hop_req asserts the cycle after CHANGE is entered.
  - hop_req drops the cycle after hop_ack and stays 00 for at least one cycle before the next coin (return-to-zero).
- An ack that arrives while the matching req is low is ignored.
- vend_done and err pulse in the cycle after the acknowledging input.

## Structure
- Shared package vm_pkg holds:
  - the state enum;
  - item codes ITEM_COLA = 01 and ITEM_PEPSI = 10;
  - coin codes COIN_5 = 01 and COIN_10 = 10;
  - the default prices.
- One sub-module, vm_change_hopper. It is loaded with the amount to refund, runs the hop_req/hop_ack handshake and the Rs10/Rs5 coin choice, and reports done and the remaining amount. vend_sequencer owns the credit register and the main FSM.

## Test plan
- Coins 10, 5, then sel = 10 (Pepsi), disp_ack 3 cycles later -> disp_req = 10, credit 15 → 0, vend_done pulses once, no hop_req, return to IDLE.
- Coins 10, 10, then sel = 01 -> vend with credit 10 remaining, then one hop_req = 10; ack it -> credit 0, IDLE.
- Coins 10, 10, 10, then coin 5 -> coin_reject pulses, credit stays 30. Then cancel -> hop_req 10 three times, each with a return-to-zero gap.
- Coin 5, sel = 10 -> sel ignored, credit 5. Then TIMEOUT_CYC idle cycles -> hop_req = 01 exactly at the timeout, credit 0 after ack.
- Credit 15, sel = 10, then disp_fault -> err pulse, credit 15 refunded as hop_req 10 then 05. A coin inserted during VEND is rejected.
- Credit 25 in CHANGE with reset asserted mid-handshake -> all outputs 0 immediately. After reset is released, coin 5 gives credit 5.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared definitions for the two-item vending machine: FSM encodings,
// item/coin codes and the default price list.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } vm_state_t;

  typedef enum logic [1:0] {
    HOP_IDLE = 2'd0,
    HOP_GAP  = 2'd1,
    HOP_REQ  = 2'd2
  } hop_state_t;

  localparam logic [1:0] ITEM_COLA  = 2'b01;
  localparam logic [1:0] ITEM_PEPSI = 2'b10;
  localparam logic [1:0] COIN_5     = 2'b01;
  localparam logic [1:0] COIN_10    = 2'b10;

  localparam int PRICE_COLA_DEF  = 10;
  localparam int PRICE_PEPSI_DEF = 15;
  localparam int CREDIT_MAX_DEF  = 30;
  localparam int TIMEOUT_CYC_DEF = 1000;
  localparam int CW_DEF          = 6;

  // Face value in Rs of a coin code; 00 and 11 are worth nothing.
  function automatic logic [3:0] coin_value(input logic [1:0] code);
    logic [3:0] v;
    v = 4'd0;
    if (code == COIN_5)  v = 4'd5;
    if (code == COIN_10) v = 4'd10;
    return v;
  endfunction

endpackage

// File: rtl/vend_if.sv
// Bus between the sequencer and its environment (front panel + actuators).
// Handshake: a req (disp_req / hop_req) is held nonzero until the matching
// ack is seen on a rising clk edge; an ack while the req is zero means nothing.
interface vend_if
  import vm_pkg::*;
#(
  parameter int CW = CW_DEF
) ();

  logic [1:0]    coin;
  logic [1:0]    sel;
  logic          cancel;
  logic [1:0]    disp_req;
  logic          disp_ack;
  logic          disp_fault;
  logic [1:0]    hop_req;
  logic          hop_ack;
  logic [CW-1:0] credit;
  logic          busy;
  logic          coin_reject;
  logic          vend_done;
  logic          err;
  vm_state_t     dbg_state;
  hop_state_t    dbg_hop_state;

  // master: the sequencer, which owns the request side of both handshakes
  modport master (
    input  coin, sel, cancel, disp_ack, disp_fault, hop_ack,
    output disp_req, hop_req, credit, busy, coin_reject, vend_done, err,
           dbg_state, dbg_hop_state
  );

  modport slave (
    output coin, sel, cancel, disp_ack, disp_fault, hop_ack,
    input  disp_req, hop_req, credit, busy, coin_reject, vend_done, err,
           dbg_state, dbg_hop_state
  );

endinterface

// File: rtl/vm_change_hopper.sv
// Change payout engine: loaded with a refund amount, it pays Rs10 coins while
// at least 10 remains, then Rs5, with a zero gap on hop_req between coins.
module vm_change_hopper
  import vm_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_amt,
  input  logic          hop_ack,
  output logic [1:0]    hop_req,
  output logic [CW-1:0] pay_val,
  output logic          done,
  output logic [CW-1:0] remaining,
  output hop_state_t    state
);

  localparam logic [CW-1:0] TEN = CW'(10);

  hop_state_t    state_q, state_n;
  logic [CW-1:0] rem_q, rem_n;
  logic [1:0]    req_q, req_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HOP_IDLE;
      rem_q   <= '0;
      req_q   <= 2'b00;
    end else begin
      state_q <= state_n;
      rem_q   <= rem_n;
      req_q   <= req_n;
    end
  end

  // pay_val/done are combinational so the owner of the credit register
  // can subtract on the same edge the coin is acknowledged.
  always_comb begin
    state_n = state_q;
    rem_n   = rem_q;
    req_n   = req_q;
    pay_val = '0;
    done    = 1'b0;
    if (load) begin
      state_n = HOP_GAP;
      rem_n   = load_amt;
      req_n   = 2'b00;
    end else begin
      case (state_q)
        HOP_GAP: begin
          if (rem_q == '0) begin
            state_n = HOP_IDLE;
          end else begin
            state_n = HOP_REQ;
            req_n   = (rem_q >= TEN) ? COIN_10 : COIN_5;
          end
        end
        HOP_REQ: begin
          if (hop_ack) begin
            pay_val = CW'(coin_value(req_q));
            rem_n   = rem_q - pay_val;
            req_n   = 2'b00;
            done    = (rem_n == '0);
            state_n = done ? HOP_IDLE : HOP_GAP;
          end
        end
        default: ;
      endcase
    end
  end

  assign hop_req   = req_q;
  assign remaining = rem_q;
  assign state     = state_q;

endmodule

// File: rtl/vend_sequencer.sv
// Main vending sequencer: owns the credit register, coin acceptance, item
// selection, dispense handshake, idle timeout and hand-off to the hopper.
module vend_sequencer
  import vm_pkg::*;
#(
  parameter int PRICE_COLA  = PRICE_COLA_DEF,
  parameter int PRICE_PEPSI = PRICE_PEPSI_DEF,
  parameter int CREDIT_MAX  = CREDIT_MAX_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CW          = CW_DEF
) (
  input  logic   clk,
  input  logic   reset,
  vend_if.master bus
);

  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] P_COLA  = CW'(PRICE_COLA);
  localparam logic [CW-1:0] P_PEPSI = CW'(PRICE_PEPSI);
  localparam logic [CW:0]   C_MAX   = (CW+1)'(CREDIT_MAX);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYC - 1);

  vm_state_t     state_q, state_n;
  logic [CW-1:0] credit_q, credit_n;
  logic [1:0]    item_q, item_n;
  logic [TW-1:0] timer_q, timer_n;
  logic [1:0]    disp_req_q;
  logic          busy_q, reject_q, done_q, err_q;
  logic          reject_n, done_n, err_n;

  logic [CW-1:0] coin_v;
  logic [CW-1:0] sel_price;
  logic          coin_valid, coin_fits, coin_ok, sel_ok;

  logic          hop_load;
  logic [1:0]    hop_req;
  logic [CW-1:0] hop_pay, hop_rem;
  logic          hop_done;
  hop_state_t    hop_state;

  vm_change_hopper #(.CW(CW)) u_hopper (
    .clk       (clk),
    .reset     (reset),
    .load      (hop_load),
    .load_amt  (credit_n),
    .hop_ack   (bus.hop_ack),
    .hop_req   (hop_req),
    .pay_val   (hop_pay),
    .done      (hop_done),
    .remaining (hop_rem),
    .state     (hop_state)
  );

  always_comb begin
    coin_v     = CW'(coin_value(bus.coin));
    coin_valid = (bus.coin == COIN_5) || (bus.coin == COIN_10);
    coin_fits  = ({1'b0, credit_q} + {1'b0, coin_v}) <= C_MAX;
    sel_price  = (bus.sel == ITEM_PEPSI) ? P_PEPSI : P_COLA;
    // sel is judged against the credit held before any same-cycle coin
    sel_ok     = ((bus.sel == ITEM_COLA) || (bus.sel == ITEM_PEPSI)) &&
                 (sel_price <= credit_q);
  end

  always_comb begin
    state_n  = state_q;
    credit_n = credit_q;
    item_n   = item_q;
    timer_n  = '0;
    reject_n = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    coin_ok  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coin_valid) begin
          if (coin_fits) begin
            credit_n = credit_q + coin_v;
            state_n  = ST_COLLECT;
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (bus.cancel) begin
          state_n  = ST_CHANGE;
          reject_n = coin_valid;
        end else begin
          coin_ok  = coin_valid && coin_fits;
          reject_n = coin_valid && !coin_fits;
          if (coin_ok) credit_n = credit_q + coin_v;
          if (sel_ok) begin
            state_n = ST_VEND;
            item_n  = bus.sel;
          end else if (!coin_ok && (timer_q == T_LAST)) begin
            state_n = ST_CHANGE;
          end else begin
            timer_n = coin_ok ? '0 : timer_q + TW'(1);
          end
        end
      end
      ST_VEND: begin
        reject_n = coin_valid;
        if (bus.disp_ack) begin
          credit_n = credit_q - ((item_q == ITEM_PEPSI) ? P_PEPSI : P_COLA);
          done_n   = 1'b1;
          state_n  = (credit_n != '0) ? ST_CHANGE : ST_IDLE;
        end else if (bus.disp_fault) begin
          err_n   = 1'b1;
          state_n = ST_CHANGE;
        end
      end
      ST_CHANGE: begin
        reject_n = coin_valid;
        credit_n = hop_rem - hop_pay;
        if (hop_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    hop_load = (state_n == ST_CHANGE) && (state_q != ST_CHANGE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      item_q     <= 2'b00;
      timer_q    <= '0;
      disp_req_q <= 2'b00;
      busy_q     <= 1'b0;
      reject_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      credit_q   <= credit_n;
      item_q     <= item_n;
      timer_q    <= timer_n;
      disp_req_q <= (state_n == ST_VEND) ? item_n : 2'b00;
      busy_q     <= (state_n == ST_VEND) || (state_n == ST_CHANGE);
      reject_q   <= reject_n;
      done_q     <= done_n;
      err_q      <= err_n;
    end
  end

  assign bus.disp_req      = disp_req_q;
  assign bus.hop_req       = hop_req;
  assign bus.credit        = credit_q;
  assign bus.busy          = busy_q;
  assign bus.coin_reject   = reject_q;
  assign bus.vend_done     = done_q;
  assign bus.err           = err_q;
  assign bus.dbg_state     = state_q;
  assign bus.dbg_hop_state = hop_state;

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: scenario tasks with inline checks plus an event
// scoreboard fed by the scenarios and drained by a negedge monitor.
module tb_vend_sequencer;
  import vm_pkg::*;

  localparam int CW      = 6;
  localparam int TIMEOUT = 1000;

  localparam logic [2:0] EV_DISP = 3'd1;
  localparam logic [2:0] EV_DONE = 3'd2;
  localparam logic [2:0] EV_ERR  = 3'd3;
  localparam logic [2:0] EV_HOP  = 3'd4;
  localparam logic [2:0] EV_REJ  = 3'd5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vend_if #(.CW(CW)) bus ();

  vend_sequencer #(
    .PRICE_COLA(10), .PRICE_PEPSI(15), .CREDIT_MAX(30),
    .TIMEOUT_CYC(TIMEOUT), .CW(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int m_credit = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_obs[$];
  logic [7:0] exp_ev;
  logic [1:0] prev_disp = 2'b00;
  logic [1:0] prev_hop  = 2'b00;

  function automatic logic [7:0] ev(input logic [2:0] t, input logic [1:0] v);
    return {t, 3'b000, v};
  endfunction

  function automatic int val_of(input logic [1:0] c);
    return (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prev_disp = 2'b00;
      prev_hop  = 2'b00;
    end else begin
      mon_obs.delete();
      if (bus.disp_req != 2'b00 && prev_disp == 2'b00) mon_obs.push_back(ev(EV_DISP, bus.disp_req));
      if (bus.vend_done)   mon_obs.push_back(ev(EV_DONE, 2'b00));
      if (bus.err)         mon_obs.push_back(ev(EV_ERR, 2'b00));
      if (bus.hop_req != 2'b00 && prev_hop == 2'b00) mon_obs.push_back(ev(EV_HOP, bus.hop_req));
      if (bus.coin_reject) mon_obs.push_back(ev(EV_REJ, 2'b00));
      prev_disp = bus.disp_req;
      prev_hop  = bus.hop_req;
      foreach (mon_obs[i]) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard: observed event %h, expected none", mon_obs[i]);
        end else begin
          exp_ev = exp_q.pop_front();
          if (mon_obs[i] !== exp_ev) begin
            bad++;
            $display("FAIL scoreboard: observed event %h, expected %h", mon_obs[i], exp_ev);
          end
        end
      end
      total++;
      assert (bus.credit <= 30 && (bus.credit % 5) == 0) else begin
        bad++;
        $display("FAIL credit_range: credit=%0d, must be <=30 and a multiple of 5", bus.credit);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_coin(input logic [1:0] c, input bit ok);
    if (!ok && (c == COIN_5 || c == COIN_10)) exp_q.push_back(ev(EV_REJ, 2'b00));
    bus.coin = c;
    step();
    bus.coin = 2'b00;
    if (ok) m_credit += val_of(c);
  endtask

  task automatic serve_coin(input logic [1:0] exp_coin);
    int k;
    exp_q.push_back(ev(EV_HOP, exp_coin));
    k = 0;
    while (bus.hop_req == 2'b00 && k < 20) begin
      step();
      k++;
    end
    total++;
    if (bus.hop_req !== exp_coin) begin
      bad++;
      $display("FAIL hop_coin: hop_req=%b, expected %b", bus.hop_req, exp_coin);
    end
    if (bus.hop_req != 2'b00) begin
      repeat ($urandom_range(0, 2)) step();
      bus.hop_ack = 1'b1;
      step();
      bus.hop_ack = 1'b0;
      m_credit -= val_of(exp_coin);
      total++;
      if (bus.hop_req !== 2'b00 || bus.credit !== CW'(m_credit)) begin
        bad++;
        $display("FAIL hop_ack: hop_req=%b credit=%0d, expected 00 and %0d",
                 bus.hop_req, bus.credit, m_credit);
      end
    end
  endtask

  task automatic end_test(input string name);
    step();
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d expected events never seen", name, exp_q.size());
    end
    exp_q.delete();
    total++;
    if (bus.dbg_state !== ST_IDLE || bus.credit !== CW'(m_credit)) begin
      bad++;
      $display("FAIL %s_idle: state=%0d credit=%0d, expected IDLE and %0d",
               name, bus.dbg_state, bus.credit, m_credit);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    total++;
    if ({bus.disp_req, bus.hop_req, bus.credit, bus.busy, bus.coin_reject,
         bus.vend_done, bus.err} !== '0 || bus.dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_values: outputs=%h state=%0d, expected 0 and IDLE",
               {bus.disp_req, bus.hop_req, bus.credit}, bus.dbg_state);
    end
    reset = 1'b1;
    step();
    m_credit = 0;
  endtask

  task automatic test_pepsi_exact();
    drive_coin(COIN_10, 1);
    drive_coin(COIN_5, 1);
    total++;
    if (bus.credit !== 6'd15 || bus.dbg_state !== ST_COLLECT) begin
      bad++;
      $display("FAIL pepsi_credit: credit=%0d state=%0d, expected 15 COLLECT", bus.credit, bus.dbg_state);
    end
    exp_q.push_back(ev(EV_DISP, ITEM_PEPSI));
    bus.sel = ITEM_PEPSI;
    step();
    bus.sel = 2'b00;
    total++;
    if (bus.disp_req !== ITEM_PEPSI || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL pepsi_disp_req: disp_req=%b busy=%b, expected 10 1", bus.disp_req, bus.busy);
    end
    step();
    step();
    exp_q.push_back(ev(EV_DONE, 2'b00));
    bus.disp_ack = 1'b1;
    step();
    bus.disp_ack = 1'b0;
    m_credit = 0;
    total++;
    if (bus.credit !== 6'd0 || bus.vend_done !== 1'b1 || bus.disp_req !== 2'b00) begin
      bad++;
      $display("FAIL pepsi_ack: credit=%0d vend_done=%b disp_req=%b, expected 0 1 00",
               bus.credit, bus.vend_done, bus.disp_req);
    end
    step();
    total++;
    if (bus.vend_done !== 1'b0 || bus.hop_req !== 2'b00 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL pepsi_after: vend_done=%b hop_req=%b busy=%b, expected 0 00 0",
               bus.vend_done, bus.hop_req, bus.busy);
    end
    end_test("pepsi");
  endtask

  task automatic test_cola_change();
    drive_coin(COIN_10, 1);
    drive_coin(COIN_10, 1);
    exp_q.push_back(ev(EV_DISP, ITEM_COLA));
    bus.sel = ITEM_COLA;
    step();
    bus.sel = 2'b00;
    step();
    exp_q.push_back(ev(EV_DONE, 2'b00));
    bus.disp_ack = 1'b1;
    step();
    bus.disp_ack = 1'b0;
    m_credit = 10;
    total++;
    if (bus.credit !== 6'd10 || bus.dbg_state !== ST_CHANGE || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL cola_change: credit=%0d state=%0d busy=%b, expected 10 CHANGE 1",
               bus.credit, bus.dbg_state, bus.busy);
    end
    serve_coin(COIN_10);
    end_test("cola");
  endtask

  task automatic test_reject_cancel();
    drive_coin(COIN_10, 1);
    drive_coin(COIN_10, 1);
    drive_coin(COIN_10, 1);
    drive_coin(COIN_5, 0);
    total++;
    if (bus.credit !== 6'd30 || bus.coin_reject !== 1'b1) begin
      bad++;
      $display("FAIL over_max: credit=%0d coin_reject=%b, expected 30 1", bus.credit, bus.coin_reject);
    end
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    total++;
    if (bus.dbg_state !== ST_CHANGE || bus.hop_req !== 2'b00) begin
      bad++;
      $display("FAIL cancel_enter: state=%0d hop_req=%b, expected CHANGE 00", bus.dbg_state, bus.hop_req);
    end
    repeat (3) serve_coin(COIN_10);
    end_test("cancel");
  endtask

  task automatic test_timeout();
    int cnt;
    drive_coin(COIN_5, 1);
    bus.sel = ITEM_PEPSI;
    step();
    bus.sel = 2'b00;
    cnt = 1;
    total++;
    if (bus.credit !== 6'd5 || bus.disp_req !== 2'b00 || bus.dbg_state !== ST_COLLECT) begin
      bad++;
      $display("FAIL short_sel: credit=%0d disp_req=%b state=%0d, expected 5 00 COLLECT",
               bus.credit, bus.disp_req, bus.dbg_state);
    end
    while (bus.dbg_state == ST_COLLECT && cnt < TIMEOUT + 20) begin
      step();
      cnt++;
    end
    total++;
    if (cnt != TIMEOUT || bus.dbg_state !== ST_CHANGE) begin
      bad++;
      $display("FAIL timeout_cycles: left COLLECT after %0d cycles, expected %0d", cnt, TIMEOUT);
    end
    serve_coin(COIN_5);
    end_test("timeout");
  endtask

  task automatic test_fault_refund();
    drive_coin(COIN_10, 1);
    drive_coin(COIN_5, 1);
    exp_q.push_back(ev(EV_DISP, ITEM_PEPSI));
    bus.sel = ITEM_PEPSI;
    step();
    bus.sel = 2'b00;
    drive_coin(COIN_5, 0);
    total++;
    if (bus.coin_reject !== 1'b1 || bus.credit !== 6'd15) begin
      bad++;
      $display("FAIL vend_coin: coin_reject=%b credit=%0d, expected 1 15", bus.coin_reject, bus.credit);
    end
    exp_q.push_back(ev(EV_ERR, 2'b00));
    bus.disp_fault = 1'b1;
    step();
    bus.disp_fault = 1'b0;
    total++;
    if (bus.err !== 1'b1 || bus.credit !== 6'd15 || bus.dbg_state !== ST_CHANGE) begin
      bad++;
      $display("FAIL fault: err=%b credit=%0d state=%0d, expected 1 15 CHANGE",
               bus.err, bus.credit, bus.dbg_state);
    end
    serve_coin(COIN_10);
    serve_coin(COIN_5);
    end_test("fault");
  endtask

  task automatic test_same_cycle();
    drive_coin(COIN_10, 1);
    exp_q.push_back(ev(EV_DISP, ITEM_COLA));
    bus.sel  = ITEM_COLA;
    bus.coin = COIN_5;
    step();
    bus.sel  = 2'b00;
    bus.coin = 2'b00;
    m_credit = 15;
    total++;
    if (bus.credit !== 6'd15 || bus.disp_req !== ITEM_COLA) begin
      bad++;
      $display("FAIL sel_with_coin: credit=%0d disp_req=%b, expected 15 01", bus.credit, bus.disp_req);
    end
    exp_q.push_back(ev(EV_DONE, 2'b00));
    bus.disp_ack   = 1'b1;
    bus.disp_fault = 1'b1;
    step();
    bus.disp_ack   = 1'b0;
    bus.disp_fault = 1'b0;
    m_credit = 5;
    total++;
    if (bus.err !== 1'b0 || bus.vend_done !== 1'b1 || bus.credit !== 6'd5) begin
      bad++;
      $display("FAIL ack_over_fault: err=%b vend_done=%b credit=%0d, expected 0 1 5",
               bus.err, bus.vend_done, bus.credit);
    end
    serve_coin(COIN_5);
    // stray inputs in IDLE: cancel, invalid coin, acks with no request
    bus.cancel   = 1'b1;
    bus.coin     = 2'b11;
    bus.hop_ack  = 1'b1;
    bus.disp_ack = 1'b1;
    step();
    bus.cancel   = 1'b0;
    bus.coin     = 2'b00;
    bus.hop_ack  = 1'b0;
    bus.disp_ack = 1'b0;
    total++;
    if (bus.dbg_state !== ST_IDLE || bus.busy !== 1'b0 || bus.credit !== 6'd0 || bus.coin_reject !== 1'b0) begin
      bad++;
      $display("FAIL idle_ignore: state=%0d busy=%b credit=%0d rej=%b, expected IDLE 0 0 0",
               bus.dbg_state, bus.busy, bus.credit, bus.coin_reject);
    end
    drive_coin(COIN_5, 1);
    exp_q.push_back(ev(EV_REJ, 2'b00));
    bus.cancel = 1'b1;
    bus.coin   = COIN_10;
    step();
    bus.cancel = 1'b0;
    bus.coin   = 2'b00;
    total++;
    if (bus.credit !== 6'd5 || bus.dbg_state !== ST_CHANGE) begin
      bad++;
      $display("FAIL cancel_coin: credit=%0d state=%0d, expected 5 CHANGE", bus.credit, bus.dbg_state);
    end
    serve_coin(COIN_5);
    end_test("same_cycle");
  endtask

  task automatic test_reset_mid();
    int k;
    drive_coin(COIN_10, 1);
    drive_coin(COIN_10, 1);
    drive_coin(COIN_5, 1);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    exp_q.push_back(ev(EV_HOP, COIN_10));
    k = 0;
    while (bus.hop_req == 2'b00 && k < 20) begin
      step();
      k++;
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.hop_req !== COIN_10 || bus.credit !== 6'd25) begin
      bad++;
      $display("FAIL mid_setup: hop_req=%b credit=%0d, expected 10 25", bus.hop_req, bus.credit);
    end
    bus.hop_ack = 1'b1;
    reset = 1'b0;
    #1;
    total++;
    if ({bus.disp_req, bus.hop_req, bus.credit, bus.busy, bus.coin_reject,
         bus.vend_done, bus.err} !== '0 || bus.dbg_state !== ST_IDLE) begin
      bad++;
      $display("FAIL mid_reset: hop_req=%b credit=%0d busy=%b state=%0d, expected all 0 IDLE",
               bus.hop_req, bus.credit, bus.busy, bus.dbg_state);
    end
    bus.hop_ack = 1'b0;
    m_credit = 0;
    step();
    reset = 1'b1;
    step();
    drive_coin(COIN_5, 1);
    total++;
    if (bus.credit !== 6'd5) begin
      bad++;
      $display("FAIL post_reset: credit=%0d, expected 5", bus.credit);
    end
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    serve_coin(COIN_5);
    end_test("reset_mid");
  endtask

  task automatic test_random();
    logic [1:0] c;
    int v;
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < $urandom_range(1, 6); n++) begin
        c = 2'($urandom_range(0, 3));
        v = val_of(c);
        drive_coin(c, (v != 0) && (m_credit + v <= 30));
        total++;
        if (bus.credit !== CW'(m_credit)) begin
          bad++;
          $display("FAIL rand_credit: credit=%0d, expected %0d", bus.credit, m_credit);
        end
      end
      if (m_credit > 0) begin
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        while (m_credit > 0) serve_coin((m_credit >= 10) ? COIN_10 : COIN_5);
      end
      end_test("random");
    end
  endtask

  initial begin
    bus.coin       = 2'b00;
    bus.sel        = 2'b00;
    bus.cancel     = 1'b0;
    bus.disp_ack   = 1'b0;
    bus.disp_fault = 1'b0;
    bus.hop_ack    = 1'b0;
    test_reset();
    test_pepsi_exact();
    test_cola_change();
    test_reject_cancel();
    test_timeout();
    test_fault_refund();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
